shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Multi-cycle shift controller that sits directly upstream of the 16-bit single-step shifter in the datapath and also consumes its output.
- Iterates the shifter N times (N = 0..15) on a captured operand, feeding each result back as the next input.
- Presents the final value with a start/busy/done handshake.
- Gives the datapath shifts by arbitrary amounts with no barrel shifter; the shifter itself is unchanged.

Parameters:
- WIDTH, 16, datapath and shifter width.
- CNT_W, 4, width of the shift-amount field; maximum amount is 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- din  input  WIDTH  operand captured on the accepted start
- op  input  2  shift code captured on start: 00 pass, 01 left, 10 logical right, 11 arithmetic right
- amount  input  CNT_W  number of single-bit steps
- sh_in  output  WIDTH  to shifter input; equals internal accumulator acc
- sh_code  output  2  to shifter control; equals captured op
- sh_out  input  WIDTH  from shifter output
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; result valid
- result  output  WIDTH  final shifted value; held until next completion

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE; acc=0, op_q=00, cnt=0, result=0, done=0, busy=0.
  - Any in-flight operation is discarded.
- States: IDLE, RUN, DONE. busy = (state != IDLE). done = (state == DONE).
- IDLE:
  - start=1 at edge k: acc<=din, op_q<=op, cnt<=amount.
  - If amount==0, go to DONE and load result<=din at the same edge.
  - Otherwise go to RUN.
  - start=0: stay in IDLE.
- RUN, at each edge:
  - acc<=sh_out and cnt<=cnt-1.
  - If cnt==1, also load result<=sh_out and go to DONE.
- DONE:
  - done=1 for exactly one cycle; next edge returns to IDLE.
  - A start in the DONE cycle is ignored; a new start is accepted in the next IDLE cycle at the earliest.
- Latency: done is high in the cycle after edge k+amount. Throughput is one operation per amount+2 cycles.
- start while busy: ignored; din, op and amount are don't-care.
- sh_in and sh_code are combinational from the registers; the shifter is combinational, so one step completes per cycle.
- op=00 with amount>0: runs the full count and result = din.
- amount at maximum (15): cnt counts 15..1 with no wrap; exactly 15 steps.
- result changes only on the edge entering DONE; it is stable otherwise, including during the next RUN.

Optional Feature:
- Macro: SHIFT_SEQ_EARLY_EXIT_EN
- Defined: in RUN, if sh_out==acc (fixed point: all-zero after a logical shift, all-ones/all-zero after an arithmetic shift, or pass op), go to DONE at that edge with result<=sh_out, regardless of cnt.
  - done therefore arrives no later than without the macro, and result is identical.
  - A fixed point already present at entry exits after one RUN cycle.
- Not defined: always exactly `amount` steps; no comparator is synthesised.

Test Plan:
- Left shift: reset_n low then high; start with din=16'h0001, op=01, amount=4 → busy high from edge k+1; done pulses one cycle after edge k+4; result=16'h0010.
- Arithmetic right: din=16'h8000, op=11, amount=3 → result=16'hF000. Same with op=10 → 16'h1000.
- Zero amount: din=16'hBEEF, amount=0 → done in the cycle after edge k; result=16'hBEEF; busy high for that single cycle only.
- Max amount with early exit: din=16'h00F0, op=10, amount=15 → result=16'h0000.
  - Without the macro, done follows edge k+15.
  - With SHIFT_SEQ_EARLY_EXIT_EN, done follows edge k+9.
- Protocol:
  - A second start with din=16'hFFFF during RUN is ignored; result is from the first operation.
  - Asserting reset_n=0 mid-RUN immediately forces busy=0, done=0, result=0.
  - After release, a fresh start (din=16'h0003, op=01, amount=1) gives result=16'h0006.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: iterates an external 16-bit single-step shifter N times (N = 0..2^CNT_W-1)
//   on a captured operand. The result is valid with a one-cycle done pulse after amount+1 edges.
// Backpressure: start is sampled only in IDLE. A start while busy, or in the DONE cycle, is ignored.
// Optional: define SHIFT_SEQ_EARLY_EXIT_EN to leave RUN early once the shifter reaches a fixed point.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] sh_in,
  output logic [1:0]       sh_code,
  input  logic [WIDTH-1:0] sh_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             finish;

  // The shifter is combinational, so it is driven straight from the registers.
  assign sh_in   = acc_q;
  assign sh_code = op_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;

  // Next-state logic: capture on start, step once per cycle in RUN, pulse DONE for one cycle.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    finish   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d = din;
          op_d  = op;
          cnt_d = amount;
          if (amount == CNT_ZERO) begin
            // Zero-step request: the operand is already the answer.
            result_d = din;
            state_d  = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d  = sh_out;
        cnt_d  = cnt_q - CNT_ONE;
        finish = (cnt_q == CNT_ONE);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        // A step that leaves the value unchanged will never change it again.
        if (sh_out == acc_q) begin
          finish = 1'b1;
        end
`endif
        if (finish) begin
          result_d = sh_out;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        // Any start seen here is dropped; the next one is taken in IDLE.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers. The status outputs are registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      op_q     <= 2'b00;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a combinational single-step shifter model around it.
// Expected results are queued when a start is driven and compared when done is observed.
// The expected early-exit latency follows SHIFT_SEQ_EARLY_EXIT_EN.
module tb_shift_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] din;
  logic [1:0]  op;
  logic [3:0]  amount;
  logic [15:0] sh_in;
  logic [1:0]  sh_code;
  logic [15:0] sh_out;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  shift_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .din     (din),
    .op      (op),
    .amount  (amount),
    .sh_in   (sh_in),
    .sh_code (sh_code),
    .sh_out  (sh_out),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-step shifter that the sequencer drives and consumes.
  always_comb begin
    sh_out = sh_in;
    case (sh_code)
      2'b01:   sh_out = {sh_in[14:0], 1'b0};
      2'b10:   sh_out = {1'b0, sh_in[15:1]};
      2'b11:   sh_out = {sh_in[15], sh_in[15:1]};
      default: sh_out = sh_in;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start one operation at a negedge, then follow it through to done and one cycle beyond.
  task automatic run_op(input string tag, input logic [15:0] d, input logic [1:0] o,
                        input logic [3:0] a, input logic [15:0] exp_res,
                        input int exp_lat, input bit poke);
    int cyc;
    logic [15:0] prev;
    logic [15:0] exp;
    prev = result;
    exp_q.push_back(exp_res);
    din = d; op = o; amount = a; start = 1'b1;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    if (a != 4'd0) chk({tag, "_hold"}, {16'd0, result}, {16'd0, prev});
    while (!done && cyc < 40) begin
      if (poke && cyc == 2) begin
        start = 1'b1; din = 16'hFFFF; op = 2'b01; amount = 4'd1;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0;
    end
    chk({tag, "_lat"}, cyc, exp_lat);
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else exp = 16'hXXXX;
    chk({tag, "_res"}, {16'd0, result}, {16'd0, exp});
    // A start in the DONE cycle must be dropped.
    start = 1'b1; din = 16'h1234; op = 2'b01; amount = 4'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle_res"}, {16'd0, result}, {16'd0, exp});
  endtask

  initial begin
    int lat_max;
    int lat_pass;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    lat_max  = 10;
    lat_pass = 2;
`else
    lat_max  = 16;
    lat_pass = 6;
`endif
    reset_n = 1'b0; start = 1'b0; din = '0; op = '0; amount = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_sh_in", {16'd0, sh_in}, 32'd0);
    chk("rst_sh_code", {30'd0, sh_code}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op("lsl4",   16'h0001, 2'b01, 4'd4,  16'h0010, 5, 1'b0);
    run_op("asr3",   16'h8000, 2'b11, 4'd3,  16'hF000, 4, 1'b0);
    run_op("lsr3",   16'h8000, 2'b10, 4'd3,  16'h1000, 4, 1'b0);
    run_op("zero",   16'hBEEF, 2'b01, 4'd0,  16'hBEEF, 1, 1'b0);
    run_op("max15",  16'h00F0, 2'b10, 4'd15, 16'h0000, lat_max, 1'b0);
    run_op("pass5",  16'hA5A5, 2'b00, 4'd5,  16'hA5A5, lat_pass, 1'b0);
    run_op("poke",   16'h0001, 2'b01, 4'd4,  16'h0010, 5, 1'b1);

    // Reset mid-RUN must clear everything immediately.
    din = 16'h0001; op = 2'b01; amount = 4'd10; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_result", {16'd0, result}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op("after_rst", 16'h0003, 2'b01, 4'd1, 16'h0006, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
